// File: rtl/b_load_ctrl.sv
// -----------------------------------------------------------------------------
// b_load_ctrl
//   Clock-B consumer stage of a multi-cycle-path crossing. When the B-side
//   valid FSM reports bvalid, this block samples the A-domain data bus, which
//   A holds stable. It pulses bload back to that FSM and toggles b_ack as the
//   acknowledge to the A domain. Each captured word is pushed into a small
//   first-word-fall-through FIFO, which is read through a valid/ready port.
//
// Ports
//   clk_b       in   clock B, all logic on posedge
//   rst_b       in   synchronous reset, active-high
//   bvalid      in   adata is stable and may be sampled
//   adata       in   [DW-1:0] A-domain data bus
//   bload       out  one-cycle load strobe (word captured this cycle)
//   b_ack       out  acknowledge toggle, flips once per captured word
//   dout        out  [DW-1:0] FIFO head word
//   dout_valid  out  FIFO non-empty
//   dout_ready  in   consumer accepts dout when dout_valid & dout_ready
//   fifo_cnt    out  [CW-1:0] FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module b_load_ctrl #(
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk_b,
    input  logic          rst_b,
    input  logic          bvalid,
    input  logic [DW-1:0] adata,
    output logic          bload,
    output logic          b_ack,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] fifo_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WDROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          b_ack_q, b_ack_d;
    logic          push;
    logic          pop;

    // FIFO storage carries data only, so it is not reset.
    logic [DW-1:0] mem [DEPTH];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        b_ack_d  = b_ack_q;
        push     = (state_q == LOAD);
        pop      = (cnt_q != '0) && dout_ready;

        case (state_q)
            // The space check is made here only. Between this point and the
            // LOAD write no other push can occur, and pops only free space,
            // so the write cannot overflow.
            IDLE:    if (bvalid && (cnt_q < CW'(DEPTH))) state_d = LOAD;
            LOAD:    state_d = WDROP;
            // Hold here until the B-side FSM has left READY, so a word that
            // is still presented is not captured a second time.
            WDROP:   if (!bvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            b_ack_d  = ~b_ack_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        // A simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_b) begin
        if (rst_b) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            b_ack_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            b_ack_q  <= b_ack_d;
        end
    end

    // Reset suppresses the write of a load that is in flight.
    always_ff @(posedge clk_b) begin
        if (!rst_b && push) begin
            mem[wr_ptr_q] <= adata;
        end
    end

    assign bload      = (state_q == LOAD);
    assign b_ack      = b_ack_q;
    assign dout       = mem[rd_ptr_q];
    assign dout_valid = (cnt_q != '0);
    assign fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_b_load_ctrl.sv
module tb_b_load_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk_b = 1'b0;
    logic          rst_b;
    logic          bvalid;
    logic [DW-1:0] adata;
    logic          bload;
    logic          b_ack;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [CW-1:0] fifo_cnt;

    b_load_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk_b      (clk_b),
        .rst_b      (rst_b),
        .bvalid     (bvalid),
        .adata      (adata),
        .bload      (bload),
        .b_ack      (b_ack),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .fifo_cnt   (fifo_cnt)
    );

    always #5 clk_b = ~clk_b;

    // Reference model: a queue of stored words plus a few transaction flags.
    logic [DW-1:0] q[$];
    bit            pending;   // a word is presented and not yet captured
    bit            bload_m;   // expected strobe in the current cycle
    bit            ack_m;     // expected ack level (parity of captures)
    int            toggles;
    logic          ack_prev;
    int            n_assert;
    int            n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model from the pre-edge inputs, then check.
    task automatic step();
        bit nb;
        @(posedge clk_b);
        if (rst_b) begin
            q.delete();
            ack_m   = 1'b0;
            bload_m = 1'b0;
        end else begin
            nb = bvalid && pending && (q.size() < DEPTH) && !bload_m;
            if (q.size() != 0 && dout_ready) void'(q.pop_front());
            if (bload_m) begin
                q.push_back(adata);
                ack_m   = ~ack_m;
                pending = 1'b0;
            end
            bload_m = nb;
        end
        #1;
        check("bload", 32'(bload), 32'(bload_m));
        check("b_ack", 32'(b_ack), 32'(ack_m));
        check("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
        check("dout_valid", 32'(dout_valid), 32'(q.size() != 0));
        if (q.size() != 0) check("dout", 32'(dout), 32'(q[0]));
        if (b_ack !== ack_prev) toggles++;
        ack_prev = b_ack;
    endtask

    task automatic start_word(input logic [DW-1:0] d);
        adata   = d;
        bvalid  = 1'b1;
        pending = 1'b1;
    endtask

    // Wait (bounded) for the capture, then drop bvalid the cycle after the
    // strobe as the B-side FSM does, and spend the one WDROP cycle.
    task automatic finish_word(input int maxc, input bit rnd);
        int n;
        n = 0;
        while (pending && n < maxc) begin
            if (rnd) dout_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        n_assert++;
        assert (!pending) else begin
            n_fail++;
            $error("FAIL capture_timeout: pending %0d expected 0", pending);
        end
        pending = 1'b0;
        bvalid  = 1'b0;
        adata   = DW'($urandom);
        if (rnd) dout_ready = 1'($urandom_range(0, 1));
        step();
    endtask

    task automatic drain();
        int n;
        n = 0;
        dout_ready = 1'b1;
        while (q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        dout_ready = 1'b0;
        step();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        toggles  = 0;
        ack_prev = 1'b0;
        pending  = 1'b0;
        bload_m  = 1'b0;
        ack_m    = 1'b0;

        // T1: reset held with bvalid high
        rst_b      = 1'b1;
        bvalid     = 1'b1;
        adata      = '0;
        dout_ready = 1'b0;
        step();
        step();
        bvalid = 1'b0;
        rst_b  = 1'b0;
        step();

        // T2: single word
        start_word(8'hA5);
        finish_word(5, 1'b0);
        drain();

        // T3: fill to DEPTH, fifth word blocked until one pop
        for (int i = 1; i <= 4; i++) begin
            start_word(DW'(i));
            finish_word(5, 1'b0);
        end
        start_word(8'h05);
        repeat (3) step();
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        finish_word(5, 1'b0);
        drain();

        // T4: push and pop in the same cycle at occupancy 2
        start_word(8'h11);
        finish_word(5, 1'b0);
        start_word(8'h22);
        finish_word(5, 1'b0);
        start_word(8'h33);
        step();
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        finish_word(5, 1'b0);
        drain();

        // T5: ten random words with random consumer stalls, pointers wrap
        toggles = 0;
        for (int i = 0; i < 10; i++) begin
            start_word(DW'($urandom));
            finish_word(40, 1'b1);
        end
        drain();
        check("ack_toggles", 32'(toggles), 32'd10);

        // T6: reset asserted during the load strobe cycle
        start_word(8'h5C);
        step();
        rst_b = 1'b1;
        step();
        rst_b   = 1'b0;
        bvalid  = 1'b0;
        pending = 1'b0;
        step();
        start_word(8'h77);
        finish_word(5, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
